// File: rtl/cp0_exc_stack.sv
// CP0 exception/interrupt control: Status/Cause registers, IRQ masking with
// lowest-index priority, and a nested EPC stack holding {saved IE, return PC}.
module cp0_exc_stack #(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     NIRQ     = 4,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [WIDTH-1:0] VECTOR  = 32'h0000_0008,
  parameter bit              VECTORED = 1'b0
) (
  input  logic                         Clk,
  input  logic                         Clrn,
  input  logic [NIRQ-1:0]              Irq,
  input  logic                         Valid,
  input  logic [WIDTH-1:0]             PC_now,
  input  logic [WIDTH-1:0]             PC_next,
  input  logic                         Exc,
  input  logic [4:0]                   Exc_code,
  input  logic                         Eret,
  input  logic                         Mtc0,
  input  logic [4:0]                   Rd,
  input  logic [WIDTH-1:0]             Qb,
  output logic [WIDTH-1:0]             Rdata,
  output logic                         Redirect,
  output logic [WIDTH-1:0]             Target,
  output logic                         Inta,
  output logic [WIDTH-1:0]             Epc,
  output logic [$clog2(DEPTH+1)-1:0]   Level
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] stk_pc [DEPTH];
  logic             stk_ie [DEPTH];
  logic             ie, ovf;
  logic [NIRQ-1:0]  mask, irq_q;
  logic [4:0]       exc_code;
  logic             redirect_q, inta_q;
  logic [WIDTH-1:0] target_q;

  logic [WIDTH-1:0] top_pc;
  logic             top_ie;
  logic [NIRQ-1:0]  pend;
  logic             found;
  logic [2:0]       win_idx;
  logic [WIDTH-1:0] int_target;
  logic             full, empty;
  logic             take_exc, take_eret, take_int, wr_status, wr_epc;
  logic [SPW-1:0]   push_slot, top_slot;
  logic [WIDTH-1:0] status_v, cause_v;

  assign full      = (sp == SPW'(DEPTH));
  assign empty     = (sp == '0);
  assign top_slot  = sp - SPW'(1);
  assign push_slot = full ? SPW'(DEPTH - 1) : sp;
  assign pend      = irq_q & mask;

  always_comb begin
    top_pc = '0;
    top_ie = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!empty && SPW'(i) == top_slot) begin
        top_pc = stk_pc[i];
        top_ie = stk_ie[i];
      end
    end
  end

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (pend[i] && !found) begin
        found   = 1'b1;
        win_idx = 3'(i);
      end
    end
    int_target = VECTORED ? VECTOR + (WIDTH'(win_idx) << 3) : VECTOR;
  end

  // An Eret is an event in its own right even on an empty stack: it still
  // blocks interrupts and Mtc0 on that edge.
  assign take_exc  = Valid & Exc;
  assign take_eret = Valid & ~Exc & Eret & ~empty;
  assign take_int  = Valid & ~Exc & ~Eret & ie & (sp < SPW'(DEPTH)) & (|pend);
  assign wr_status = Valid & ~Exc & ~Eret & ~take_int & Mtc0 & (Rd == 5'd12);
  assign wr_epc    = Valid & ~Exc & ~Eret & ~take_int & Mtc0 & (Rd == 5'd14) & ~empty;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      sp         <= '0;
      ie         <= 1'b0;
      ovf        <= 1'b0;
      mask       <= '0;
      irq_q      <= '0;
      exc_code   <= '0;
      redirect_q <= 1'b0;
      inta_q     <= 1'b0;
      target_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stk_pc[i] <= '0;
        stk_ie[i] <= 1'b0;
      end
    end else begin
      irq_q      <= Irq;
      redirect_q <= 1'b0;
      inta_q     <= 1'b0;
      if (take_exc) begin
        exc_code   <= Exc_code;
        ie         <= 1'b0;
        target_q   <= VECTOR;
        redirect_q <= 1'b1;
        if (full) ovf <= 1'b1;
        else      sp  <= sp + SPW'(1);
      end else if (take_eret) begin
        ie         <= top_ie;
        target_q   <= top_pc;
        redirect_q <= 1'b1;
        sp         <= sp - SPW'(1);
      end else if (take_int) begin
        exc_code   <= '0;
        ie         <= 1'b0;
        target_q   <= int_target;
        redirect_q <= 1'b1;
        inta_q     <= 1'b1;
        sp         <= sp + SPW'(1);
      end else if (wr_status) begin
        ie   <= Qb[0];
        ovf  <= Qb[1];
        mask <= Qb[8 +: NIRQ];
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((take_exc || take_int) && SPW'(i) == push_slot) begin
          stk_pc[i] <= take_exc ? PC_now : PC_next;
          stk_ie[i] <= ie;
        end else if (wr_epc && SPW'(i) == top_slot) begin
          stk_pc[i] <= Qb;
        end
      end
    end
  end

  always_comb begin
    status_v           = '0;
    status_v[0]        = ie;
    status_v[1]        = ovf;
    status_v[8 +: NIRQ] = mask;
    cause_v            = '0;
    cause_v[6:2]       = exc_code;
    cause_v[8 +: NIRQ] = irq_q;
    case (Rd)
      5'd12:   Rdata = status_v;
      5'd13:   Rdata = cause_v;
      5'd14:   Rdata = top_pc;
      default: Rdata = '0;
    endcase
  end

  assign Redirect = redirect_q;
  assign Inta     = inta_q;
  assign Target   = target_q;
  assign Epc      = top_pc;
  assign Level    = sp;

endmodule

// File: tb/tb_cp0_exc_stack.sv
// Self-checking bench for cp0_exc_stack: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cp0_exc_stack;

  localparam int unsigned NIRQ  = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] VEC   = 32'h0000_0008;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b1;
  logic [3:0]  Irq = '0;
  logic        Valid = 1'b0, Exc = 1'b0, Eret = 1'b0, Mtc0 = 1'b0;
  logic [4:0]  Exc_code = '0, Rd = '0;
  logic [31:0] PC_now = '0, PC_next = '0, Qb = '0;
  logic [31:0] Rdata, Target, Epc;
  logic        Redirect, Inta;
  logic [1:0]  Level;

  cp0_exc_stack #(
    .WIDTH(32), .NIRQ(4), .DEPTH(2), .VECTOR(32'h0000_0008), .VECTORED(1'b1)
  ) dut (
    .Clk(Clk), .Clrn(Clrn), .Irq(Irq), .Valid(Valid), .PC_now(PC_now),
    .PC_next(PC_next), .Exc(Exc), .Exc_code(Exc_code), .Eret(Eret),
    .Mtc0(Mtc0), .Rd(Rd), .Qb(Qb), .Rdata(Rdata), .Redirect(Redirect),
    .Target(Target), .Inta(Inta), .Epc(Epc), .Level(Level)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit ie; logic [31:0] pc; } ent_t;
  ent_t        stk[$];
  bit          m_ie, m_ovf, m_red, m_inta;
  logic [3:0]  m_mask, m_irqq;
  logic [4:0]  m_code;
  logic [31:0] m_target;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ie = 0; m_ovf = 0; m_red = 0; m_inta = 0;
    m_mask = '0; m_irqq = '0; m_code = '0; m_target = '0;
  endtask

  task automatic model_edge();
    logic [3:0] pend;
    int idx;
    ent_t e;
    m_red  = 0;
    m_inta = 0;
    pend   = m_irqq & m_mask;
    if (Valid && Exc) begin
      e.ie = m_ie; e.pc = PC_now;
      if (stk.size() == DEPTH) begin
        stk[stk.size()-1] = e;
        m_ovf = 1;
      end else stk.push_back(e);
      m_code = Exc_code; m_ie = 0; m_target = VEC; m_red = 1;
    end else if (Valid && Eret) begin
      if (stk.size() > 0) begin
        e = stk.pop_back();
        m_ie = e.ie; m_target = e.pc; m_red = 1;
      end
    end else if (Valid && m_ie && stk.size() < DEPTH && pend != 0) begin
      idx = 0;
      while (!pend[idx]) idx++;
      e.ie = m_ie; e.pc = PC_next;
      stk.push_back(e);
      m_code = 0; m_ie = 0; m_target = VEC + idx * 8; m_red = 1; m_inta = 1;
    end else if (Valid && Mtc0) begin
      if (Rd == 12) begin
        m_ie = Qb[0]; m_ovf = Qb[1]; m_mask = Qb[11:8];
      end else if (Rd == 14 && stk.size() > 0) begin
        stk[stk.size()-1].pc = Qb;
      end
    end
    m_irqq = Irq;
  endtask

  function automatic logic [31:0] m_epc();
    return (stk.size() > 0) ? stk[stk.size()-1].pc : 32'h0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] rd);
    case (rd)
      5'd12:   return (32'(m_mask) << 8) | (32'(m_ovf) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_irqq) << 8) | (32'(m_code) << 2);
      5'd14:   return m_epc();
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare_all();
    check("redirect", 32'(Redirect), 32'(m_red));
    check("inta", 32'(Inta), 32'(m_inta));
    check("level", 32'(Level), 32'(stk.size()));
    check("epc", Epc, m_epc());
    check("rdata", Rdata, m_rdata(Rd));
    if (m_red) check("target", Target, m_target);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic exc, input logic [4:0] code,
                        input logic eret, input logic mtc0, input logic [4:0] rd,
                        input logic [31:0] qb, input logic [3:0] irq,
                        input logic [31:0] pcn, input logic [31:0] pcx);
    Valid = v; Exc = exc; Exc_code = code; Eret = eret; Mtc0 = mtc0;
    Rd = rd; Qb = qb; Irq = irq; PC_now = pcn; PC_next = pcx;
  endtask

  initial begin
    model_reset();
    #1 Clrn = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rd = 5'd12;
    #1;
    compare_all();
    check("rst_target", Target, 32'h0);
    check("rst_status", Rdata, 32'h0);
    Clrn = 1'b1;

    // Unmask IRQ0 and enable, then take the interrupt two edges after Irq rises
    set_in(1, 0, 0, 0, 1, 12, 32'h0000_0101, 4'b0001, 0, 0);      tick();
    check("status_wr", Rdata, 32'h0000_0101);
    set_in(1, 0, 0, 0, 0, 12, 0, 4'b0001, 32'h3c, 32'h40);         tick();
    check("int0_red", 32'(Redirect), 32'd1);
    check("int0_inta", 32'(Inta), 32'd1);
    check("int0_target", Target, 32'h8);
    check("int0_epc", Epc, 32'h40);
    check("int0_level", 32'(Level), 32'd1);
    check("int0_status", Rdata, 32'h0000_0100);
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    check("eret0_target", Target, 32'h40);

    // Synchronous exception and return
    set_in(1, 1, 12, 0, 0, 13, 0, 4'b0000, 32'h100, 32'h104);      tick();
    check("exc_target", Target, 32'h8);
    check("exc_epc", Epc, 32'h100);
    check("exc_cause", Rdata, 32'h30);
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    check("eret_target", Target, 32'h100);
    check("eret_level", 32'(Level), 32'd0);
    check("eret_ie", Rdata, 32'h0000_0101);

    // Nesting up to and past DEPTH
    set_in(1, 1, 4, 0, 0, 12, 0, 4'b0000, 32'h10, 32'h14);         tick();
    set_in(1, 1, 5, 0, 0, 12, 0, 4'b0000, 32'h20, 32'h24);         tick();
    check("nest_level", 32'(Level), 32'd2);
    set_in(1, 1, 6, 0, 0, 12, 0, 4'b0000, 32'h30, 32'h34);         tick();
    check("ovf_epc", Epc, 32'h30);
    check("ovf_level", 32'(Level), 32'd2);
    check("ovf_status", Rdata, 32'h0000_0102);
    set_in(1, 0, 0, 0, 1, 12, 32'h0000_0101, 4'b0001, 0, 0);       tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 12, 0, 4'b0001, 32'h50, 32'h54);       tick();
      check("full_no_int", 32'(Redirect), 32'd0);
    end
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    check("pop_ovf_target", Target, 32'h30);
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    check("pop_first_target", Target, 32'h10);

    // Vectored interrupt: IRQ2 wins over IRQ3
    set_in(1, 0, 0, 0, 1, 12, 32'h0000_0C01, 4'b1100, 0, 0);       tick();
    set_in(1, 0, 0, 0, 0, 12, 0, 4'b1100, 32'h1fc, 32'h200);       tick();
    check("vec_target", Target, 32'h18);
    check("vec_inta", 32'(Inta), 32'd1);

    // Exc wins over a same-edge Mtc0; Eret on an empty stack is a no-op
    set_in(1, 1, 3, 0, 1, 12, 32'h0000_0F03, 4'b0000, 32'h300, 0); tick();
    check("exc_mtc0_drop", Rdata, 32'h0000_0C00);
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    set_in(1, 0, 0, 1, 0, 12, 0, 4'b0000, 0, 0);                   tick();
    check("eret_empty_red", 32'(Redirect), 32'd0);
    check("eret_empty_status", Rdata, 32'h0000_0C01);

    // Asynchronous reset while an interrupt redirect is in flight
    set_in(1, 0, 0, 0, 0, 12, 0, 4'b0100, 0, 32'h400);             tick();
    tick();
    check("pre_rst_inta", 32'(Inta), 32'd1);
    #2 Clrn = 1'b0;
    #1;
    model_reset();
    check("arst_red", 32'(Redirect), 32'd0);
    check("arst_inta", 32'(Inta), 32'd0);
    check("arst_level", 32'(Level), 32'd0);
    check("arst_epc", Epc, 32'h0);
    check("arst_status", Rdata, 32'h0);
    set_in(0, 0, 0, 0, 0, 12, 0, 4'b0000, 0, 0);
    @(negedge Clk);
    Clrn = 1'b1;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      case ($urandom_range(0, 3))
        0: rd = 5'd12;
        1: rd = 5'd13;
        2: rd = 5'd14;
        default: rd = 5'($urandom);
      endcase
      set_in($urandom_range(0, 9) < 8,
             $urandom_range(0, 9) == 0,
             5'($urandom),
             $urandom_range(0, 6) == 0,
             $urandom_range(0, 4) == 0,
             rd,
             $urandom,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : Irq,
             $urandom, $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
